// File: rtl/err_calc.sv
// err_calc: gathers a serial 8-sensor IR frame into a position-weighted error,
// then scales and saturates it and tracks line presence with hysteresis.
module err_calc #(
   parameter int ERR_SHIFT = 2,
   parameter int LINE_ON   = 1024,
   parameter int LINE_OFF  = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ir_vld,
   input  logic [2:0]  ir_idx,
   input  logic [11:0] ir_val,
   output logic [10:0] err_sat,
   output logic        err_vld,
   output logic        line_present,
   output logic        seq_err
);
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam logic [14:0] LON  = 15'(LINE_ON);
   localparam logic [14:0] LOFF = 15'(LINE_OFF);
   state_t             r_state, w_state_n;
   logic [2:0]         r_exp, w_exp_n;
   logic signed [16:0] r_wsum, w_wsum_n;
   logic [14:0]        r_rsum, w_rsum_n;
   logic               w_seq, w_done;
   logic [1:0]         w_sh;
   logic signed [16:0] w_mag, w_term, w_w, w_s;
   logic [14:0]        w_r;
   logic [10:0]        w_sat;
   // Weights are powers of two: +8,+4,+2,+1 on the left half, mirrored negative on the right.
   assign w_sh   = ir_idx[2] ? ir_idx[1:0] : 2'd3 - ir_idx[1:0];
   assign w_mag  = 17'(ir_val) << w_sh;
   assign w_term = ir_idx[2] ? -w_mag : w_mag;
   assign w_w    = r_wsum + w_term;
   assign w_r    = r_rsum + 15'(ir_val);
   assign w_s    = w_w >>> ERR_SHIFT;
   assign w_sat  = (w_s > 17'sd1023) ? 11'h3FF : (w_s < -17'sd1024) ? 11'h400 : w_s[10:0];
   always_comb begin
      w_state_n = r_state;
      w_exp_n   = r_exp;
      w_wsum_n  = r_wsum;
      w_rsum_n  = r_rsum;
      w_seq     = 1'b0;
      w_done    = 1'b0;
      if (ir_vld) begin
         if (ir_idx == 3'd0) begin
            // A fresh idx0 always (re)starts a frame; mid-frame it also flags the violation.
            w_seq     = (r_state == ACCUM);
            w_state_n = ACCUM;
            w_exp_n   = 3'd1;
            w_wsum_n  = w_term;
            w_rsum_n  = 15'(ir_val);
         end else if (r_state == IDLE) begin
            w_seq = 1'b1;
         end else if (ir_idx == r_exp && r_exp != 3'd7) begin
            w_exp_n  = r_exp + 3'd1;
            w_wsum_n = w_w;
            w_rsum_n = w_r;
         end else if (ir_idx == 3'd7 && r_exp == 3'd7) begin
            w_done    = 1'b1;
            w_state_n = IDLE;
         end else begin
            w_seq     = 1'b1;
            w_state_n = IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_exp        <= 3'd0;
         r_wsum       <= '0;
         r_rsum       <= '0;
         err_sat      <= '0;
         err_vld      <= 1'b0;
         line_present <= 1'b0;
         seq_err      <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_exp        <= w_exp_n;
         r_wsum       <= w_wsum_n;
         r_rsum       <= w_rsum_n;
         err_vld      <= w_done;
         seq_err      <= w_seq;
         err_sat      <= w_done ? w_sat : err_sat;
         line_present <= !w_done ? line_present : (w_r > LON) ? 1'b1 : (w_r < LOFF) ? 1'b0 : line_present;
      end
   end
endmodule

// File: tb/tb_err_calc.sv
// tb_err_calc: directed frames with hand-computed error, saturation, hysteresis
// and sequencing expectations.
module tb_err_calc;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ir_vld = 1'b0;
   logic [2:0]  ir_idx = '0;
   logic [11:0] ir_val = '0;
   logic [10:0] err_sat;
   logic        err_vld, line_present, seq_err;
   int checks = 0;
   int failures = 0;
   err_calc dut (
      .clk(clk), .rst(rst), .ir_vld(ir_vld), .ir_idx(ir_idx), .ir_val(ir_val),
      .err_sat(err_sat), .err_vld(err_vld), .line_present(line_present), .seq_err(seq_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   task automatic send(input int idx, input int val);
      ir_vld = 1'b1;
      ir_idx = 3'(idx);
      ir_val = 12'(val);
      tick();
      ir_vld = 1'b0;
   endtask
   task automatic run_frame(input string tag, input int v[8], input int e_sat, input int e_lp);
      for (int i = 0; i < 8; i++) begin
         send(i, v[i]);
         if (i == 6) check({tag, "_vld_early"}, int'(err_vld), 0);
      end
      check({tag, "_vld"}, int'(err_vld), 1);
      check({tag, "_sat"}, int'($signed(err_sat)), e_sat);
      check({tag, "_lp"}, int'(line_present), e_lp);
      check({tag, "_seq"}, int'(seq_err), 0);
      tick();
      check({tag, "_vld_once"}, int'(err_vld), 0);
   endtask
   initial begin
      do_reset();
      check("rst_sat", int'(err_sat), 0);
      check("rst_vld", int'(err_vld), 0);
      check("rst_lp", int'(line_present), 0);
      check("rst_seq", int'(seq_err), 0);
      run_frame("t1_left_sat", '{4095, 0, 0, 0, 0, 0, 0, 0}, 1023, 1);
      run_frame("t2_balanced", '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000}, 0, 1);
      do_reset();
      run_frame("t3_r400", '{0, 0, 0, 400, 0, 0, 0, 0}, 100, 0);
      run_frame("t3_r800", '{0, 0, 0, 800, 0, 0, 0, 0}, 200, 0);
      run_frame("t3_r1100", '{0, 0, 0, 1100, 0, 0, 0, 0}, 275, 1);
      run_frame("t3_r600", '{0, 0, 0, 600, 0, 0, 0, 0}, 150, 1);
      run_frame("t3_r500", '{0, 0, 0, 500, 0, 0, 0, 0}, 125, 0);
      run_frame("t4_right_sat", '{0, 0, 0, 0, 0, 0, 0, 4095}, -1024, 1);
      run_frame("t4_idx6", '{0, 0, 0, 0, 0, 0, 300, 0}, -300, 0);
      send(0, 0); send(1, 0); send(2, 0); send(5, 0);
      check("t5_skip_seq", int'(seq_err), 1);
      check("t5_skip_vld", int'(err_vld), 0);
      tick();
      check("t5_skip_seq_once", int'(seq_err), 0);
      check("t5_skip_sat_hold", int'($signed(err_sat)), -300);
      run_frame("t5_after", '{0, 0, 0, 0, 100, 0, 0, 0}, -25, 0);
      send(0, 500); send(1, 500); send(0, 10);
      check("t5_restart_seq", int'(seq_err), 1);
      send(1, 0);
      check("t5_restart_seq_once", int'(seq_err), 0);
      send(2, 40); send(3, 0); send(4, 0); send(5, 0); send(6, 0);
      check("t5_restart_early", int'(err_vld), 0);
      send(7, 0);
      check("t5_restart_vld", int'(err_vld), 1);
      check("t5_restart_sat", int'($signed(err_sat)), 40);
      for (int i = 0; i < 5; i++) send(i, 1000);
      do_reset();
      check("t6_rst_sat", int'(err_sat), 0);
      check("t6_rst_vld", int'(err_vld), 0);
      check("t6_rst_seq", int'(seq_err), 0);
      for (int i = 5; i < 8; i++) begin
         send(i, 1000);
         check($sformatf("t6_seq_idx%0d", i), int'(seq_err), 1);
         check($sformatf("t6_vld_idx%0d", i), int'(err_vld), 0);
      end
      check("t6_sat_zero", int'(err_sat), 0);
      check("t6_lp_zero", int'(line_present), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
